// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage pipeline. Combines load-use
// hazards, taken-branch flushes, multi-cycle mul/div occupancy and data-memory
// wait into one prioritised set of write-enable / bubble / flush controls for
// the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//
// Parameters:
//   MD_LATENCY  total freeze cycles for one mul/div op, start cycle included
//               (legal range 2..15)
//   CNT_WIDTH   width of the stall-cycle counter
//
// Configuration macro:
//   STALL_CNT_EN  defined   -> stall_cnt_o counts non-IDLE cycles with
//                              pc_write_o=0, wrapping at 2^CNT_WIDTH
//                 undefined -> no counter register, stall_cnt_o tied to 0
//
// Ports:
//   clk_i, rst_i       rising-edge clock, asynchronous active-high reset
//   start_i            leave IDLE (sampled only in IDLE)
//   load_use_i         load-use hazard in ID
//   branch_taken_i     branch in ID resolved taken
//   md_start_i         mul/div instruction present in EX
//   dmem_stall_i       data memory not ready this cycle
//   pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o
//                      register write enables
//   if_id_flush_o      zero IF/ID on this edge
//   id_ex_bubble_o, ex_mem_bubble_o, mem_wb_bubble_o
//                      load zero control into the named register
//   md_done_o          first RUN cycle after a mul/div busy phase
//   state_o            IDLE=00, RUN=01, MD_BUSY=10
//   stall_cnt_o        stall-cycle count
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 load_use_i,
  input  logic                 branch_taken_i,
  input  logic                 md_start_i,
  input  logic                 dmem_stall_i,
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_write_o,
  output logic                 id_ex_bubble_o,
  output logic                 ex_mem_write_o,
  output logic                 ex_mem_bubble_o,
  output logic                 mem_wb_bubble_o,
  output logic                 md_done_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MD_BUSY = 2'b10
  } state_t;

  // The start cycle in RUN is the first freeze cycle, so MD_BUSY lasts
  // MD_LATENCY-1 cycles.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_md_cnt, w_md_cnt_nxt;
  logic       r_md_done, w_md_done_nxt;
  logic       w_md_trigger;
  logic       w_md_hold;

  // md_done masks md_start for one cycle so the mul/div still sitting in EX
  // on its completion cycle does not start a second busy phase.
  assign w_md_trigger = (r_state == ST_RUN) && md_start_i && !r_md_done;
  assign w_md_hold    = (r_state == ST_MD_BUSY) || w_md_trigger;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_md_cnt  <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_md_cnt  <= w_md_cnt_nxt;
      r_md_done <= w_md_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The counter runs every MD_BUSY cycle regardless of
  // dmem_stall_i, so a memory wait never lengthens the mul/div window.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first; without it a
  // missed branch would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_md_cnt_nxt  = r_md_cnt;
    w_md_done_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_md_trigger) begin
          w_state_nxt  = ST_MD_BUSY;
          w_md_cnt_nxt = MD_LOAD;
        end
      end
      ST_MD_BUSY: begin
        if (r_md_cnt == 4'd1) begin
          w_state_nxt   = ST_RUN;
          w_md_cnt_nxt  = '0;
          w_md_done_nxt = 1'b1;
        end else begin
          w_md_cnt_nxt = r_md_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls: first matching rule wins. Any active stall rule
  // suppresses the branch flush; ID re-presents the branch later.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b1;
    ex_mem_bubble_o = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (r_state == ST_IDLE) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      id_ex_bubble_o  = 1'b1;
      ex_mem_bubble_o = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (dmem_stall_i) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (w_md_hold) begin
      // Freeze the front end; EX/MEM takes bubbles while the unit iterates.
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_bubble_o = 1'b1;
    end else if (load_use_i) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_bubble_o  = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o   = 1'b1;
    end
  end

  assign md_done_o = r_md_done;
  assign state_o   = r_state;

  // ---------------------------------------------------------------------------
  // Optional stall-cycle counter
  // ---------------------------------------------------------------------------
`ifdef STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_IDLE) && !pc_write_o) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Self-checking bench: directed sequences followed by randomised stimulus,
// compared every cycle against a behavioural model that tracks "running",
// "mul/div cycles remaining", "done flag" and a stall tally, and derives the
// expected controls from the priority rules directly.
// Control vector order: {pc_w, if_id_w, if_id_flush, id_ex_w, id_ex_bubble,
//                        ex_mem_w, ex_mem_bubble, mem_wb_bubble}
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  localparam int MD_LAT = 4;
  localparam int CW     = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i, load_use_i, branch_taken_i, md_start_i, dmem_stall_i;
  logic          pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o;
  logic          id_ex_bubble_o, ex_mem_write_o, ex_mem_bubble_o, mem_wb_bubble_o;
  logic          md_done_o;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MD_LATENCY(MD_LAT), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .load_use_i     (load_use_i),
    .branch_taken_i (branch_taken_i),
    .md_start_i     (md_start_i),
    .dmem_stall_i   (dmem_stall_i),
    .pc_write_o     (pc_write_o),
    .if_id_write_o  (if_id_write_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_write_o  (id_ex_write_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .ex_mem_write_o (ex_mem_write_o),
    .ex_mem_bubble_o(ex_mem_bubble_o),
    .mem_wb_bubble_o(mem_wb_bubble_o),
    .md_done_o      (md_done_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  wire [7:0] w_obs_ctrl = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
                           id_ex_bubble_o, ex_mem_write_o, ex_mem_bubble_o,
                           mem_wb_bubble_o};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_run;     // left IDLE
  int          m_busy;    // mul/div busy cycles still to go after the start cycle
  bit          m_done;    // completion cycle flag
  int unsigned m_stalls;  // cycles outside IDLE with PC frozen

  localparam logic [7:0] C_IDLE = 8'b0000_1011;
  localparam logic [7:0] C_DMEM = 8'b0000_0001;
  localparam logic [7:0] C_MD   = 8'b0000_0110;
  localparam logic [7:0] C_LU   = 8'b0001_1100;
  localparam logic [7:0] C_BR   = 8'b1111_0100;
  localparam logic [7:0] C_DEF  = 8'b1101_0100;

  function automatic logic [7:0] exp_ctrl(input bit lu, input bit br, input bit md, input bit dm);
    if (!m_run)                          return C_IDLE;
    if (dm)                              return C_DMEM;
    if (m_busy > 0 || (md && !m_done))   return C_MD;
    if (lu)                              return C_LU;
    if (br)                              return C_BR;
    return C_DEF;
  endfunction

  function automatic logic [1:0] exp_state();
    if (!m_run)     return 2'b00;
    if (m_busy > 0) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_CNT_EN
    return m_stalls;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_done = 0; m_stalls = 0;
  endtask

  task automatic model_step(input bit st, input bit lu, input bit br, input bit md, input bit dm);
    logic [7:0] c;
    bit trig;
    c = exp_ctrl(lu, br, md, dm);
    if (m_run && !c[7]) m_stalls++;
    if (!m_run) begin
      m_run = st;
    end else if (m_busy > 0) begin
      m_done = (m_busy == 1);
      m_busy--;
    end else begin
      trig   = md && !m_done;
      m_done = 0;
      if (trig) m_busy = MD_LAT - 1;
    end
  endtask

  task automatic check_all(input string tag, input bit lu, input bit br, input bit md, input bit dm);
    check({tag, ".ctrl"},  {24'd0, w_obs_ctrl},  {24'd0, exp_ctrl(lu, br, md, dm)});
    check({tag, ".state"}, {30'd0, state_o},     {30'd0, exp_state()});
    check({tag, ".done"},  {31'd0, md_done_o},   {31'd0, m_done});
    check({tag, ".cnt"},   stall_cnt_o,          exp_cnt());
  endtask

  // One clock cycle: inputs driven just after the rising edge, outputs checked
  // mid-cycle, then the model advances with the edge.
  task automatic cycle(input string tag, input bit st, input bit lu, input bit br,
                       input bit md, input bit dm);
    start_i = st; load_use_i = lu; branch_taken_i = br; md_start_i = md; dmem_stall_i = dm;
    #3;
    check_all(tag, lu, br, md, dm);
    @(posedge clk);
    model_step(st, lu, br, md, dm);
    #1;
  endtask

  // Asynchronous reset pulse asserted mid-cycle, away from any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check({tag, ".ctrl"},  {24'd0, w_obs_ctrl}, {24'd0, C_IDLE});
    check({tag, ".state"}, {30'd0, state_o},    32'd0);
    check({tag, ".done"},  {31'd0, md_done_o},  32'd0);
    check({tag, ".cnt"},   stall_cnt_o,         32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 0; load_use_i = 0; branch_taken_i = 0; md_start_i = 0; dmem_stall_i = 0;
    model_reset();
    #2;
    check_all("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Idle until start, then run.
    cycle("idle",  0, 0, 0, 0, 0);
    cycle("start", 1, 0, 0, 0, 0);
    cycle("run0",  0, 0, 0, 0, 0);
    // Single load-use cycle, then defaults.
    cycle("lu",    0, 1, 0, 0, 0);
    cycle("lu_after", 0, 0, 0, 0, 0);
    // Mul/div held through its 4 freeze cycles plus the done cycle.
    for (int i = 0; i < MD_LAT + 1; i++) cycle("md_hold", 0, 0, 0, 1, 0);
    cycle("md_after", 0, 0, 0, 0, 0);
    // Mul/div with two dmem waits inside the busy window.
    cycle("md2_start", 0, 0, 0, 1, 0);
    cycle("md2_dm1",   0, 0, 0, 1, 1);
    cycle("md2_dm2",   0, 0, 0, 1, 1);
    cycle("md2_last",  0, 0, 0, 1, 0);
    cycle("md2_done",  0, 0, 0, 1, 0);
    // Mul/div and dmem in the same RUN cycle.
    cycle("md3_dm",    0, 0, 0, 1, 1);
    for (int i = 0; i < MD_LAT; i++) cycle("md3", 0, 1, 1, 1, 0);
    // Branch against load-use, then branch alone.
    cycle("br_lu", 0, 1, 1, 0, 0);
    cycle("br",    0, 0, 1, 0, 0);
    // Reset in the middle of a busy phase.
    cycle("md4_start", 0, 0, 0, 1, 0);
    cycle("md4_busy",  0, 0, 0, 1, 0);
    async_reset("rst_mid_md");
    cycle("post_rst", 0, 1, 1, 1, 0);

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      bit st, lu, br, md, dm;
      st = ($urandom_range(3) == 0);
      lu = ($urandom_range(4) == 0);
      br = ($urandom_range(4) == 0);
      md = ($urandom_range(5) == 0) || (md_start_i && $urandom_range(1) == 0);
      dm = ($urandom_range(5) == 0);
      if ($urandom_range(299) == 0) async_reset("rand_rst");
      else cycle("rand", st, lu, br, md, dm);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. Merges load-use hazard, taken-branch flush, multi-cycle mul/div occupancy and data-memory wait into one prioritised set of write-enable/bubble/flush controls for PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Holds a small FSM: post-reset idle, normal run, and a counted mul/div busy phase.

## Interface
Parameters:
- MD_LATENCY, 4, total freeze cycles for one mul/div op, including its start cycle; legal range 2..15
- CNT_WIDTH, 32, stall-counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  leave IDLE; sampled only in IDLE
- load_use_i  in  1  load-use hazard in ID, from the hazard detection logic
- branch_taken_i  in  1  branch in ID resolved taken
- md_start_i  in  1  mul/div instruction present in EX
- dmem_stall_i  in  1  data memory not ready this cycle
- pc_write_o  out  1  PC write enable
- if_id_write_o  out  1  IF/ID write enable
- if_id_flush_o  out  1  zero IF/ID on this edge
- id_ex_write_o  out  1  ID/EX write enable
- id_ex_bubble_o  out  1  load zero control into ID/EX
- ex_mem_write_o  out  1  EX/MEM write enable
- ex_mem_bubble_o  out  1  load zero control into EX/MEM
- mem_wb_bubble_o  out  1  load zero control into MEM/WB
- md_done_o  out  1  first RUN cycle after MD_BUSY
- state_o  out  2  IDLE=00, RUN=01, MD_BUSY=10
- stall_cnt_o  out  CNT_WIDTH  stall-cycle count

## Operation
- States: IDLE (reset) -> RUN when start_i=1. RUN -> MD_BUSY when md_start_i=1 and md_done_o=0; md_cnt loads MD_LATENCY-1. MD_BUSY: md_cnt==1 -> RUN with md_done_o=1 for one cycle; else md_cnt-1. No path back to IDLE except reset.
- Outputs are combinational from state and inputs; first matching rule wins:
  - IDLE: all *_write_o=0, all *_bubble_o=1, if_id_flush_o=0.
  - dmem_stall_i=1: pc/if_id/id_ex/ex_mem write=0; mem_wb_bubble_o=1; other bubbles 0; flush 0.
  - MD_BUSY, or RUN with md_start_i=1 and md_done_o=0: pc/if_id/id_ex write=0; ex_mem_write_o=1, ex_mem_bubble_o=1.
  - load_use_i=1: pc/if_id write=0; id_ex_bubble_o=1; id_ex/ex_mem write=1.
  - branch_taken_i=1: all writes 1; if_id_flush_o=1.
  - Default: all writes 1, bubbles 0, flush 0.
- md_done_o masks md_start_i for one cycle, so the held mul/div does not retrigger.
- md_start_i, load_use_i and branch_taken_i are ignored in MD_BUSY, except for the md_cnt behaviour defined under Timing.
- md_cnt decrements every MD_BUSY cycle, including dmem_stall_i cycles.

## Timing
- Reset (asynchronous): state IDLE, md_cnt=0, md_done_o=0, stall_cnt_o=0. Outputs immediately take IDLE values.
- Stall and flush responses are the same cycle as the request, with zero latency.
- A mul/div freezes PC and IF/ID for exactly MD_LATENCY cycles. dmem_stall_i cycles overlapping that window do not extend it.
- md_start_i and dmem_stall_i in the same RUN cycle: the dmem outputs win that cycle, and the MD_BUSY transition still occurs.
- If reset asserts mid-MD_BUSY, the controller returns to IDLE and md_cnt clears.
- If branch_taken_i arrives with any stall rule active, no flush is issued. ID re-presents the branch later.

## Configuration
- STALL_CNT_EN defined: stall_cnt_o increments each cycle in RUN/MD_BUSY where pc_write_o=0, and wraps at 2^CNT_WIDTH.
- STALL_CNT_EN undefined: no counter register, and stall_cnt_o is tied to 0.

## Test plan
- Reset -> IDLE, pc_write_o=0 and all bubbles=1; start_i=1 -> state_o=01 next cycle and all writes=1.
- RUN, load_use_i=1 for one cycle -> that cycle pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; next cycle defaults.
- MD_LATENCY=4, md_start_i held high -> pc_write_o=0 for exactly 4 cycles and md_done_o=1 on the 5th; no retrigger.
- MD_BUSY with dmem_stall_i=1 on 2 cycles -> mem_wb_bubble_o=1 on those cycles, and exit still occurs 4 cycles after start.
- branch_taken_i=1 with load_use_i=1 -> if_id_flush_o=0; branch_taken_i alone -> if_id_flush_o=1.
- With STALL_CNT_EN defined: run the above sequence -> stall_cnt_o equals the count of pc_write_o=0 cycles outside IDLE; asynchronous reset mid-sequence -> stall_cnt_o=0.
